div_iter: RTL and testbench

- Iterative radix-2 restoring integer divider for the RISC-V M extension: DIV, DIVU, REM, REMU.
- It is the inverse counterpart of the pipelined multiplier in the MDU.
- Operands are taken from the Execute-stage forwarding muxes; the divider stalls the pipeline while busy and presents quotient and remainder for Memory-stage writeback.
- It computes one quotient bit per cycle, with fast-path completion for the architecturally defined special cases.

---
 rtl/div_iter_if.sv | 42 ++++
 rtl/div_iter.sv | 191 +++++++++++++++++++
 tb/tb_div_iter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// ============================================================================
// div_iter_if : operand, control and result bundle of the iterative divider
// Optional macro DIVW_EN adds the W64E word-op select.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface div_iter_if #(
    parameter int XLEN = 64
);
    logic            FlushE;
    logic            StallM;
    logic            DivStartE;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic [2:0]      Funct3E;
`ifdef DIVW_EN
    logic            W64E;
`endif
    logic            DivBusyE;
    logic            DivDoneM;
    logic [XLEN-1:0] QuotM;
    logic [XLEN-1:0] RemM;

    modport master (
`ifdef DIVW_EN
        output W64E,
`endif
        output FlushE, StallM, DivStartE, ForwardedSrcAE, ForwardedSrcBE, Funct3E,
        input  DivBusyE, DivDoneM, QuotM, RemM
    );

    modport slave (
`ifdef DIVW_EN
        input  W64E,
`endif
        input  FlushE, StallM, DivStartE, ForwardedSrcAE, ForwardedSrcBE, Funct3E,
        output DivBusyE, DivDoneM, QuotM, RemM
    );
endinterface

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// div_iter : radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit
//            per cycle, single-cycle completion for divide-by-zero/overflow.
// Optional macro DIVW_EN (XLEN=64 only) enables 32-bit word ops via W64E.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_iter #(
    parameter int XLEN = 64
) (
    input  wire logic   clk,
    input  wire logic   reset,
    div_iter_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q;
    logic            negq_q, negr_q;
    logic [XLEN-1:0] quot_out_q, rem_out_q;
`ifdef DIVW_EN
    logic            w64_q;
`endif

    logic            w_signed, w_a_sign, w_b_sign, w_ovf_pat, w_special;
    logic [XLEN-1:0] w_a, w_b, w_a_abs, w_b_abs, w_quo_init;
    logic [XLEN-1:0] w_spec_q, w_spec_r;
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_fit;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin;
    logic            w_start, w_accept, w_finish;
    logic            w_unused;

    // Funct3E[1] only selects Q vs R downstream.
    assign w_unused = bus.Funct3E[1];
    assign w_signed = bus.Funct3E[2] & ~bus.Funct3E[0];

    // Operand preparation: magnitudes, signs and special-case detection.
    always_comb begin
        w_a        = bus.ForwardedSrcAE;
        w_b        = bus.ForwardedSrcBE;
        w_a_sign   = w_signed & bus.ForwardedSrcAE[XLEN-1];
        w_b_sign   = w_signed & bus.ForwardedSrcBE[XLEN-1];
        w_ovf_pat  = (bus.ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.ForwardedSrcBE);
`ifdef DIVW_EN
        if (bus.W64E) begin
            w_a_sign  = w_signed & bus.ForwardedSrcAE[31];
            w_b_sign  = w_signed & bus.ForwardedSrcBE[31];
            w_a       = {{(XLEN-32){w_a_sign}}, bus.ForwardedSrcAE[31:0]};
            w_b       = {{(XLEN-32){w_b_sign}}, bus.ForwardedSrcBE[31:0]};
            w_ovf_pat = (bus.ForwardedSrcAE[31:0] == 32'h8000_0000) & (&bus.ForwardedSrcBE[31:0]);
        end
`endif
        w_a_abs    = w_a_sign ? -w_a : w_a;
        w_b_abs    = w_b_sign ? -w_b : w_b;
        w_quo_init = w_a_abs;
`ifdef DIVW_EN
        // Word ops run 32 iterations, so the dividend starts in the top half.
        if (bus.W64E) begin
            w_quo_init = {w_a_abs[31:0], 32'h0};
        end
`endif
        w_special  = (w_b == '0) | (w_signed & w_ovf_pat);
        w_spec_q   = (w_b == '0) ? '1  : w_a;
        w_spec_r   = (w_b == '0) ? w_a : '0;
`ifdef DIVW_EN
        if (bus.W64E) begin
            w_spec_q = {{(XLEN-32){w_spec_q[31]}}, w_spec_q[31:0]};
            w_spec_r = {{(XLEN-32){w_spec_r[31]}}, w_spec_r[31:0]};
        end
`endif
    end

    // One restoring step; the extra bit keeps 2R+1 from overflowing.
    always_comb begin
        w_shift  = {rem_q, quo_q[XLEN-1]};
        w_diff   = w_shift - {1'b0, div_q};
        w_fit    = ~w_diff[XLEN];
        w_rem_nx = w_fit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        w_quo_nx = {quo_q[XLEN-2:0], w_fit};
        w_q_fin  = negq_q ? -w_quo_nx : w_quo_nx;
        w_r_fin  = negr_q ? -w_rem_nx : w_rem_nx;
`ifdef DIVW_EN
        if (w64_q) begin
            w_q_fin = {{(XLEN-32){w_q_fin[31]}}, w_q_fin[31:0]};
            w_r_fin = {{(XLEN-32){w_r_fin[31]}}, w_r_fin[31:0]};
        end
`endif
    end

    assign w_start  = bus.DivStartE & ~bus.FlushE;
    assign w_accept = w_start & ((state_q == S_IDLE) | ((state_q == S_DONE) & ~bus.StallM));
    assign w_finish = (state_q == S_BUSY) & ~bus.FlushE & (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = w_special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.FlushE) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.FlushE) begin
                    state_d = S_IDLE;
                end else if (!bus.StallM) begin
                    if (bus.DivStartE) begin
                        state_d = w_special ? S_DONE : S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
`ifdef DIVW_EN
            w64_q      <= 1'b0;
`endif
        end else if (w_accept) begin
            if (w_special) begin
                quot_out_q <= w_spec_q;
                rem_out_q  <= w_spec_r;
            end else begin
                rem_q  <= '0;
                quo_q  <= w_quo_init;
                div_q  <= w_b_abs;
                negq_q <= w_a_sign ^ w_b_sign;
                negr_q <= w_a_sign;
                cnt_q  <= CNT_LAST;
`ifdef DIVW_EN
                w64_q  <= bus.W64E;
                if (bus.W64E) begin
                    cnt_q <= CW'(31);
                end
`endif
            end
        end else if (state_q == S_BUSY) begin
            rem_q <= w_rem_nx;
            quo_q <= w_quo_nx;
            cnt_q <= cnt_q - 1'b1;
            if (w_finish) begin
                quot_out_q <= w_q_fin;
                rem_out_q  <= w_r_fin;
            end
        end
    end

    assign bus.DivBusyE = (state_q == S_BUSY);
    assign bus.DivDoneM = (state_q == S_DONE);
    assign bus.QuotM    = quot_out_q;
    assign bus.RemM     = rem_out_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// tb_div_iter : directed vector table plus flush/stall/back-to-back sequences
// With DIVW_EN the table runs as word ops on a 64-bit divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_div_iter;
`ifdef DIVW_EN
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_iter_if #(.XLEN(XLEN)) bus ();
    div_iter #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vt[12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ext(input logic [31:0] x);
`ifdef DIVW_EN
        return {{32{x[31]}}, x};
`else
        return x;
`endif
    endfunction

    function automatic logic [XLEN-1:0] opnd(input logic [31:0] x);
`ifdef DIVW_EN
        return {32'hDEAD_BEEF, x};
`else
        return x;
`endif
    endfunction

    // Drive a start at the current negedge, release it at the next one.
    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.Funct3E        = f3;
        bus.ForwardedSrcAE = a;
        bus.ForwardedSrcBE = b;
        bus.DivStartE      = 1'b1;
        @(negedge clk);
        bus.DivStartE      = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (!bus.DivDoneM && lat < 200) begin
            if (bus.DivBusyE) busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] eq, input logic [XLEN-1:0] er, input int elat);
        int lat, busy;
        @(negedge clk);
        issue(f3, a, b);
        wait_done(lat, busy);
        check({nm, "_lat"}, 64'(lat), 64'(elat));
        check({nm, "_busy"}, 64'(busy), 64'((elat == 1) ? 0 : elat - 1));
        check({nm, "_Q"}, 64'(bus.QuotM), 64'(eq));
        check({nm, "_R"}, 64'(bus.RemM), 64'(er));
    endtask

    initial begin
        logic [XLEN-1:0] hold_q, hold_r;
        int lat, busy;
        bit saw_done;

        vt[0]  = '{3'b100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vt[1]  = '{3'b101, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         33};
        vt[2]  = '{3'b110, 32'd100,       32'h0,         32'hFFFF_FFFF, 32'd100,       1};
        vt[3]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1};
        vt[4]  = '{3'b111, 32'd7,         32'hFFFF_FFFF, 32'h0,         32'd7,         33};
        vt[5]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33};
        vt[6]  = '{3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33};
        vt[7]  = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33};
        vt[8]  = '{3'b100, 32'h8000_0000, 32'h1,         32'h8000_0000, 32'h0,         33};
        vt[9]  = '{3'b001, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 32'd1,         33};
        vt[10] = '{3'b101, 32'h0,         32'd5,         32'h0,         32'h0,         33};
        vt[11] = '{3'b100, 32'd50,        32'd7,         32'd7,         32'd1,         33};

        reset              = 1'b1;
        bus.FlushE         = 1'b0;
        bus.StallM         = 1'b0;
        bus.DivStartE      = 1'b0;
        bus.ForwardedSrcAE = '0;
        bus.ForwardedSrcBE = '0;
        bus.Funct3E        = 3'b000;
`ifdef DIVW_EN
        bus.W64E           = 1'b1;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.DivBusyE), 64'd0);
        check("rst_done", 64'(bus.DivDoneM), 64'd0);
        check("rst_Q", 64'(bus.QuotM), 64'd0);
        check("rst_R", 64'(bus.RemM), 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), vt[i].f3, opnd(vt[i].a), opnd(vt[i].b),
                   ext(vt[i].q), ext(vt[i].r), vt[i].lat);
        end

        // Start coincident with flush is ignored.
        @(negedge clk);
        bus.Funct3E = 3'b100; bus.ForwardedSrcAE = opnd(32'd9); bus.ForwardedSrcBE = opnd(32'd3);
        bus.DivStartE = 1'b1; bus.FlushE = 1'b1;
        @(negedge clk);
        bus.DivStartE = 1'b0; bus.FlushE = 1'b0;
        check("startflush_busy", 64'(bus.DivBusyE), 64'd0);
        check("startflush_done", 64'(bus.DivDoneM), 64'd0);

        // Flush mid-division leaves the previous result in place.
        run_op("pre", 3'b101, opnd(32'hFFFF_FFFF), opnd(32'h10), ext(32'h0FFF_FFFF), ext(32'hF), 33);
        hold_q = bus.QuotM;
        hold_r = bus.RemM;
        @(negedge clk);
        issue(3'b100, opnd(32'd50), opnd(32'd7));
        repeat (9) @(negedge clk);
        bus.FlushE = 1'b1;
        @(negedge clk);
        bus.FlushE = 1'b0;
        check("flush_busy", 64'(bus.DivBusyE), 64'd0);
        check("flush_done", 64'(bus.DivDoneM), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DivDoneM) saw_done = 1'b1;
        end
        check("flush_nodone", 64'(saw_done), 64'd0);
        check("flush_Q", 64'(bus.QuotM), 64'(ext(32'h0FFF_FFFF)));
        check("flush_R", 64'(bus.RemM), 64'(ext(32'hF)));
        run_op("after_flush", 3'b100, opnd(32'd50), opnd(32'd7), ext(32'd7), ext(32'd1), 33);

        // Stall holds DONE and the result.
        bus.StallM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_done", k), 64'(bus.DivDoneM), 64'd1);
            check($sformatf("stall%0d_Q", k), 64'(bus.QuotM), 64'(ext(32'd7)));
            check($sformatf("stall%0d_R", k), 64'(bus.RemM), 64'(ext(32'd1)));
        end
        bus.StallM = 1'b0;
        @(negedge clk);
        check("unstall_done", 64'(bus.DivDoneM), 64'd0);

        // Back-to-back: new start accepted directly from DONE.
        run_op("b2b_a", 3'b110, opnd(32'd100), opnd(32'd0), ext(32'hFFFF_FFFF), ext(32'd100), 1);
        issue(3'b101, opnd(32'hFFFF_FFFF), opnd(32'h10));
        wait_done(lat, busy);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_Q", 64'(bus.QuotM), 64'(ext(32'h0FFF_FFFF)));
        check("b2b_R", 64'(bus.RemM), 64'(ext(32'hF)));

`ifdef DIVW_EN
        run_op("w64_div", 3'b100, 64'h0000_0001_FFFF_FFFA, 64'd4,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        @(negedge clk);
        bus.W64E = 1'b0;
        run_op("full_divu", 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
               64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
